rot_tile_engine: RTL
====================

// Module: rot_tile_engine
// PURPOSE
//  Parametrised ping-pong tile buffer for the rotation datapath, between the DMA read and write paths on HCLK.
//  Accepts a TILE x TILE pixel tile in row-major order and emits it in rotated order.
//  Rotations are 0/90/180/270 in either direction, with an optional mirror.
//  Two banks let the next tile fill while the current tile drains.
// PARAMETERS
//  PIX_W   32  pixel/word width in bits
//  TILE    8   tile edge in pixels; power of 2, 2..64; LG = log2(TILE) as a localparam
//  CNT_W   16  width of the completed-tile counter
// PORTS
//  I_HCLK           in   1        clock
//  I_HRESET_N       in   1        asynchronous active-low reset
//  I_RTB_CLEAR      in   1        synchronous soft reset (from CTRL_RESET)
//  I_RTB_DEGREES    in   2        00=0, 01=90, 10=180, 11=270
//  I_RTB_DIRECTION  in   1        0=CW, 1=CCW
//  I_RTB_MIRROR     in   1        horizontal flip after rotation; present only with ROT_TILE_MIRROR_EN
//  I_RTB_IN_VALID   in   1        input pixel valid
//  I_RTB_IN_DATA    in   PIX_W    input pixel
//  O_RTB_IN_READY   out  1        buffer can accept a pixel
//  O_RTB_OUT_VALID  out  1        output pixel valid
//  O_RTB_OUT_DATA   out  PIX_W    output pixel
//  O_RTB_OUT_LAST   out  1        last pixel of tile
//  I_RTB_OUT_READY  in   1        downstream accepts
//  O_RTB_BUSY       out  1        any bank not EMPTY, or output skid non-empty
//  O_RTB_TILE_CNT   out  CNT_W    tiles fully drained; wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async or CLEAR): both banks EMPTY, pointers 0, skid empty, TILE_CNT=0.
//    Outputs: IN_READY=1 (0 during async reset), OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, BUSY=0.
//    CLEAR has priority over every same-cycle event.
//  - Bank states: EMPTY -> FILLING (first input beat) -> FULL (beat TILE*TILE-1) -> DRAINING -> EMPTY (last read issued).
//  - Write side: beat accepted when IN_VALID && IN_READY.
//    IN_READY=1 iff write bank is EMPTY or FILLING.
//    Write pointer wr_idx (2*LG bits) increments per beat. At TILE*TILE-1 it wraps to 0 and the write bank toggles.
//  - Mode latch: {DEGREES,DIRECTION[,MIRROR]} is captured per bank on the first beat of that bank.
//    Mid-tile changes have no effect.
//  - Effective CW rotation k: k = DIRECTION ? (4-DEGREES)%4 : DEGREES.
//  - Read side: a FULL bank becomes DRAINING when no bank is draining. Output index (r,c) runs row-major.
//    With MIRROR, c'=TILE-1-c; otherwise c'=c. Source (sr,sc) by k:
//    0:(r,c')  1:(TILE-1-c',r)  2:(TILE-1-r,TILE-1-c')  3:(c',TILE-1-r)
//    RAM address = bank*TILE*TILE + sr*TILE + sc; all arithmetic is modulo TILE (LG bits).
//  - RAM: 1 write port, 1 synchronous read port, latency 1 cycle. Read data enters a 2-entry output skid FIFO.
//    A read issues only if skid occupancy plus reads in flight is < 2. No pixel is dropped or duplicated under any OUT_READY pattern.
//  - Latency: with OUT_READY held 1, OUT_VALID rises 2 cycles after the cycle in which the last input beat is accepted.
//    Output then sustains 1 pixel/cycle.
//  - OUT_LAST is 1 with the pixel at output index TILE*TILE-1.
//    TILE_CNT increments when that pixel handshakes.
//  - Simultaneous fill-complete and drain-complete in the same cycle: the filled bank goes FULL, the drained bank goes EMPTY.
//    The next cycle the FULL bank starts draining and IN_READY stays 1.
//  - Both banks FULL: IN_READY=0 until the draining bank's last read issues.
//  - OUT_VALID/OUT_DATA/OUT_LAST hold stable while OUT_VALID && !OUT_READY.
// CONFIGURATION
//  ROT_TILE_MIRROR_EN
//   - Defined: I_RTB_MIRROR port exists, is latched per bank, and applies c'=TILE-1-c.
//   - Undefined: port absent, MIRROR treated as 0; no mirror logic is synthesised.
// STRUCTURE
//  - Package rot_pkg: mode encodings (DEG_0..DEG_270, DIR_CW/CCW), bank-state enum (EMPTY/FILLING/FULL/DRAINING),
//    and function rot_src_idx(k,mirror,r,c) used by RTL and the bench model.
//  - Sub-module rot_tile_ram: 2*TILE*TILE x PIX_W array, 1W/1R synchronous, no reset on contents.
//  - Control, pointers and skid FIFO live in rot_tile_engine.
// TESTING
//  1 TILE=4; write pixels 0..15 with DEG=00; OUT_READY=1.
//    -> out 0..15, LAST on 15, TILE_CNT=1, first OUT_VALID 2 cycles after beat 15.
//  2 TILE=4, DEG=01 DIR=0 -> out 12,8,4,0,13,9,5,1,...,15,11,7,3.
//    DEG=11 DIR=1 gives the same sequence.
//  3 DEG=10 -> out 15..0.
//    With MIRROR_EN and MIRROR=1 at DEG=00 -> out 3,2,1,0,7,6,5,4,...
//  4 Stream 3 tiles back-to-back with OUT_READY=0 -> IN_READY drops after beat 31, BUSY=1.
//    Then raise OUT_READY -> tiles drain in order, IN_READY rises after tile-0's last read issues, TILE_CNT=3.
//  5 Random OUT_READY toggling (50%) over 20 tiles -> scoreboard vs rot_src_idx; zero loss, duplication or reordering.
//  6 Assert CLEAR at pixel 7 of the draining tile while the other bank fills.
//    -> next cycle OUT_VALID=0, BUSY=0, TILE_CNT=0, IN_READY=1; a following clean tile outputs correctly.
//    Repeat with I_HRESET_N low mid-tile -> same state asynchronously.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared definitions for the rotation tile engine: mode encodings, bank state, source index map.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rot_pkg;

    // Rotation amount and direction encodings as seen on the mode inputs.
    localparam logic [1:0] DEG_0   = 2'b00;
    localparam logic [1:0] DEG_90  = 2'b01;
    localparam logic [1:0] DEG_180 = 2'b10;
    localparam logic [1:0] DEG_270 = 2'b11;
    localparam logic       DIR_CW  = 1'b0;
    localparam logic       DIR_CCW = 1'b1;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    // A CCW turn of d quarters equals a CW turn of (4-d) mod 4 quarters.
    function automatic logic [1:0] eff_k(input logic [1:0] deg, input logic dir);
        return (dir == DIR_CCW) ? 2'(2'd0 - deg) : deg;
    endfunction

    // Row-major source index {sr, sc} (lg bits each) for output position (r, c)
    // under a CW rotation of k quarters, with optional horizontal flip of the
    // output. All arithmetic is modulo 2**lg; TILE-1-x is computed as ~x.
    function automatic logic [11:0] rot_src_idx(input logic [1:0] k,
                                                input logic       mirror,
                                                input logic [5:0] r,
                                                input logic [5:0] c,
                                                input int         lg);
        logic [5:0] m;
        logic [5:0] rm;
        logic [5:0] cm;
        logic [5:0] ir;
        logic [5:0] icm;
        logic [5:0] sr;
        logic [5:0] sc;
        m   = 6'((1 << lg) - 1);
        rm  = r & m;
        cm  = mirror ? (~c & m) : (c & m);
        ir  = ~rm & m;
        icm = ~cm & m;
        case (k)
            2'd0:    begin sr = rm;  sc = cm;  end
            2'd1:    begin sr = icm; sc = rm;  end
            2'd2:    begin sr = ir;  sc = icm; end
            default: begin sr = cm;  sc = ir;  end
        endcase
        return (12'(sr) << lg) | 12'(sc);
    endfunction

endpackage

// File: rtl/rot_tile_ram.sv
// Two-bank tile storage: one write port, one synchronous read port, contents not reset.
// Latency: rd_data valid the cycle after rd_en; holds its value while rd_en is low.
// Backpressure: none; the caller decides when to read and write.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data read result.
module rot_tile_ram #(
    parameter int PIX_W = 32,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rot_tile_engine.sv
// Ping-pong tile buffer: takes TILE x TILE pixels row-major, emits them rotated (and optionally mirrored).
// Latency: first output pixel 2 cycles after the last input beat of a tile, then 1 pixel/cycle.
// Backpressure: IN_READY low while the write bank is FULL/DRAINING; reads stall when the 2-entry output skid would overflow.
// Ports: I_HCLK/I_HRESET_N clock and async reset; I_RTB_CLEAR sync clear; I_RTB_DEGREES/DIRECTION[/MIRROR] mode,
//        latched on the first beat of each tile; IN_VALID/IN_DATA/IN_READY input stream; OUT_VALID/OUT_DATA/OUT_LAST/
//        OUT_READY output stream; O_RTB_BUSY activity flag; O_RTB_TILE_CNT drained-tile count.
// Build option ROT_TILE_MIRROR_EN adds the I_RTB_MIRROR port and the horizontal flip.
module rot_tile_engine
    import rot_pkg::*;
#(
    parameter int PIX_W = 32,
    parameter int TILE  = 8,
    parameter int CNT_W = 16
) (
    input  logic             I_HCLK,
    input  logic             I_HRESET_N,
    input  logic             I_RTB_CLEAR,
    input  logic [1:0]       I_RTB_DEGREES,
    input  logic             I_RTB_DIRECTION,
`ifdef ROT_TILE_MIRROR_EN
    input  logic             I_RTB_MIRROR,
`endif
    input  logic             I_RTB_IN_VALID,
    input  logic [PIX_W-1:0] I_RTB_IN_DATA,
    output logic             O_RTB_IN_READY,
    output logic             O_RTB_OUT_VALID,
    output logic [PIX_W-1:0] O_RTB_OUT_DATA,
    output logic             O_RTB_OUT_LAST,
    input  logic             I_RTB_OUT_READY,
    output logic             O_RTB_BUSY,
    output logic [CNT_W-1:0] O_RTB_TILE_CNT
);

    localparam int LG = $clog2(TILE);
    localparam int IW = 2 * LG;
    localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};

    bank_state_t      bank_st     [2];
    bank_state_t      bank_st_nxt [2];
    logic [1:0]       bank_k      [2];
    logic             wr_bank;
    logic             rd_bank;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic [IW-1:0]    src_idx;
    logic             rd_mir;
    logic             wr_open;
    logic             wr_fire;
    logic             rd_ok;
    logic             rd_fire;
    logic             rd_last;

    // Output skid: sk0 is the head. Each entry carries {last, pixel}.
    logic [1:0]       sk_cnt;
    logic [PIX_W:0]   sk0;
    logic [PIX_W:0]   sk1;
    logic             rd_inflight;
    logic             rd_last_q;
    logic [PIX_W-1:0] ram_q;
    logic [PIX_W:0]   ram_word;
    logic [PIX_W:0]   out_word;
    logic             head_vld;
    logic             out_vld;
    logic             pop;
    logic             push;
    logic [2:0]       occ_after;
    logic [CNT_W-1:0] tile_cnt;

`ifdef ROT_TILE_MIRROR_EN
    logic bank_mir [2];
    assign rd_mir = bank_mir[rd_bank];

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            bank_mir[0] <= 1'b0;
            bank_mir[1] <= 1'b0;
        end else if (I_RTB_CLEAR) begin
            bank_mir[0] <= 1'b0;
            bank_mir[1] <= 1'b0;
        end else if (wr_fire && (wr_idx == '0)) begin
            bank_mir[wr_bank] <= I_RTB_MIRROR;
        end
    end
`else
    assign rd_mir = 1'b0;
`endif

    // ---------------- write side ----------------
    assign wr_open        = (bank_st[wr_bank] == EMPTY) || (bank_st[wr_bank] == FILLING);
    assign wr_fire        = I_RTB_IN_VALID && wr_open;
    assign O_RTB_IN_READY = I_HRESET_N && wr_open;

    // ---------------- read side ----------------
    // rd_bank always points at the bank being drained or the next one to drain,
    // so a FULL bank there can issue its first read in the same cycle it is
    // promoted to DRAINING; this is what gives the 2-cycle fill-to-output latency.
    assign rd_ok     = (bank_st[rd_bank] == FULL) || (bank_st[rd_bank] == DRAINING);
    assign head_vld  = (sk_cnt != 2'd0);
    assign out_vld   = head_vld || rd_inflight;
    assign ram_word  = {rd_last_q, ram_q};
    assign out_word  = head_vld ? sk0 : ram_word;
    assign pop       = out_vld && I_RTB_OUT_READY;
    // Data still in flight is shown directly when the skid is empty; otherwise it queues.
    assign push      = rd_inflight && (head_vld || !pop);
    // Occupancy counts buffered plus in-flight words, less the one leaving this cycle.
    assign occ_after = 3'(sk_cnt) + 3'(rd_inflight) - 3'(pop);
    assign rd_fire   = rd_ok && (occ_after < 3'd2);
    assign rd_last   = (rd_idx == LAST_IDX);

    always_comb begin
        src_idx = IW'(rot_src_idx(bank_k[rd_bank], rd_mir,
                                  6'(rd_idx[IW-1:LG]), 6'(rd_idx[LG-1:0]), LG));
    end

    // A write touches only an EMPTY/FILLING bank and a read only a FULL/DRAINING
    // one, so both updates can be applied without conflict.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st_nxt[b] = bank_st[b];
            if (wr_fire && (wr_bank == 1'(b))) begin
                bank_st_nxt[b] = (wr_idx == LAST_IDX) ? FULL : FILLING;
            end
            if (rd_ok && (rd_bank == 1'(b))) begin
                bank_st_nxt[b] = (rd_fire && rd_last) ? EMPTY : DRAINING;
            end
        end
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b] <= EMPTY;
                bank_k[b]  <= 2'd0;
            end
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            tile_cnt <= '0;
        end else if (I_RTB_CLEAR) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b] <= EMPTY;
                bank_k[b]  <= 2'd0;
            end
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            tile_cnt <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b] <= bank_st_nxt[b];
            end
            if (wr_fire) begin
                wr_idx <= wr_idx + IW'(1);
                if (wr_idx == '0) begin
                    bank_k[wr_bank] <= eff_k(I_RTB_DEGREES, I_RTB_DIRECTION);
                end
                if (wr_idx == LAST_IDX) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_idx <= rd_idx + IW'(1);
                if (rd_last) begin
                    rd_bank <= ~rd_bank;
                end
            end
            if (pop && out_word[PIX_W]) begin
                tile_cnt <= tile_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------- output skid ----------------
    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            sk_cnt      <= 2'd0;
            sk0         <= '0;
            sk1         <= '0;
            rd_inflight <= 1'b0;
            rd_last_q   <= 1'b0;
        end else if (I_RTB_CLEAR) begin
            sk_cnt      <= 2'd0;
            sk0         <= '0;
            sk1         <= '0;
            rd_inflight <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            rd_inflight <= rd_fire;
            if (rd_fire) begin
                rd_last_q <= rd_last;
            end
            case ({push, pop && head_vld})
                2'b10: begin
                    if (sk_cnt == 2'd0) begin
                        sk0 <= ram_word;
                    end else begin
                        sk1 <= ram_word;
                    end
                    sk_cnt <= sk_cnt + 2'd1;
                end
                2'b01: begin
                    sk0    <= sk1;
                    sk_cnt <= sk_cnt - 2'd1;
                end
                2'b11: begin
                    if (sk_cnt == 2'd1) begin
                        sk0 <= ram_word;
                    end else begin
                        sk0 <= sk1;
                        sk1 <= ram_word;
                    end
                end
                default: ;
            endcase
        end
    end

    rot_tile_ram #(
        .PIX_W (PIX_W),
        .AW    (IW + 1)
    ) u_ram (
        .clk     (I_HCLK),
        .wr_en   (wr_fire),
        .wr_addr ({wr_bank, wr_idx}),
        .wr_data (I_RTB_IN_DATA),
        .rd_en   (rd_fire),
        .rd_addr ({rd_bank, src_idx}),
        .rd_data (ram_q)
    );

    assign O_RTB_OUT_VALID = out_vld;
    assign O_RTB_OUT_DATA  = out_vld ? out_word[PIX_W-1:0] : '0;
    assign O_RTB_OUT_LAST  = out_vld && out_word[PIX_W];
    assign O_RTB_BUSY      = (bank_st[0] != EMPTY) || (bank_st[1] != EMPTY) || head_vld || rd_inflight;
    assign O_RTB_TILE_CNT  = tile_cnt;

endmodule
